sys_intr_regfile: RTL and testbench
===================================

Name: sys_intr_regfile

Overview:
Parametrised successor to the single-line system register file. It holds the processor's system registers and adds a multi-source interrupt front end:
- NUM_IRQ edge-detected interrupt inputs with per-source enable mask and pending latches
- fixed priority, lowest index wins
- one level of nesting via a saved-enable bit

It sits beside the decode/writeback stages. It raises int_req to the pipeline, and the pipeline answers with int_ack at its flush point.

Parameters:
DBITS, 32, data/PC width
NUM_IRQ, 4, number of interrupt sources (1..16)
IDX_BITS, 4, system register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sys_wrt_en  in  1  WSR write strobe
wrt_index  in  IDX_BITS  system register written
rd_index  in  IDX_BITS  system register read (RSR)
data_in  in  DBITS  WSR write data
pc_in  in  DBITS  return PC captured on int_ack
irq  in  NUM_IRQ  interrupt lines, already synchronous to clk
is_reti  in  1  RETI retiring this cycle
int_ack  in  1  pipeline accepts the pending interrupt
int_req  out  1  interrupt request to pipeline
data_out  out  DBITS  RSR read data
handler_addr  out  DBITS  IHA value, jump target on ack
ret_addr  out  DBITS  IRA value, jump target on RETI
debug_sys_out  out  DBITS  PCS value

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Register map:
  - 0 PCS: bit0 IE, bit1 PIE; other bits read 0
  - 1 IHA
  - 2 IRA
  - 3 IDN
  - 4 IEN: per-source mask, NUM_IRQ LSBs
  - 5 IPEND: read pending bits; WSR is write-1-to-clear
  - Other indices read 0, and writes to them are ignored.
- Reset: all registers 0, irq_prev 0, int_req 0. The reset value wins over every concurrent event.
- Edge detect: irq_prev <= irq every cycle. pend[i] sets on irq[i] & ~irq_prev[i].
  - A line held high raises only one pending event.
- int_req = PCS.IE & |(IPEND & IEN). It is combinational from registered state.
  - An irq edge in cycle t gives int_req high in cycle t+1.
- Winner = lowest index i with pend[i] & ien[i].
- int_ack while int_req = 1, at the next edge:
  - IRA <= pc_in
  - IDN <= winner index, zero-extended
  - PCS.PIE <= PCS.IE
  - PCS.IE <= 0
  - pend[winner] <= 0
- int_ack while int_req = 0 is ignored.
- is_reti (not acked the same cycle): PCS.IE <= PCS.PIE, PCS.PIE <= 1.
- Precedence in one cycle: int_ack > is_reti > WSR, per affected register. WSR to registers untouched by the ack still takes effect.
- Pending set vs clear, same bit same cycle: the new edge (set) wins over the ack clear and over the W1C clear.
- Masked sources stay pending. Enabling IEN later raises int_req the next cycle.
- data_out: combinational mux on rd_index.
  - If sys_wrt_en and wrt_index == rd_index, data_out forwards data_in. For IPEND, it shows the post-clear value.
- handler_addr = IHA; ret_addr = IRA; debug_sys_out = PCS.

Decomposition:
- Shared package sys_reg_pkg holds:
  - register index constants (PCS/IHA/IRA/IDN/IEN/IPEND)
  - PCS bit positions IE_BIT, PIE_BIT
- Sub-module irq_pending_unit (parametrised by NUM_IRQ) contains:
  - edge detect and pending latches
  - W1C and ack clear
  - priority encoder, with outputs any_req and winner_idx
- The top level holds the register bank, precedence logic and read mux.

Test Plan:
1. Reset, then WSR IEN=0xF, PCS=1, pulse irq[2] at cycle 10 → int_req=1 at cycle 11. int_ack with pc_in=0x100 → IDN=2, IRA=0x100, PCS=0b10, int_req=0.
2. Rising edges on irq[1] and irq[3] in the same cycle, IE=1, IEN=0xF → first ack gives IDN=1. After RETI (IE restored), second ack gives IDN=3.
3. IEN=0b0001, edge on irq[2] → int_req stays 0, IPEND=0b0100. WSR IEN=0b0100 → int_req=1 next cycle. WSR IPEND=0b0100 instead → pending cleared, int_req stays 0.
4. Same-cycle WSR IDN=0x55 and int_ack (winner 0) → IDN=0. RSR PCS during WSR PCS=0x3 → data_out=0x3 in that cycle.
5. Edge on irq[0] in the same cycle as the ack clearing pend[0] → pend[0] stays 1, and int_req reasserts once IE is restored.
6. reset asserted in the same cycle as int_ack and an irq edge → all registers 0, int_req=0 next cycle, IRA not updated.

Source files
------------

// File: rtl/sys_reg_pkg.sv
// Shared definitions for the system register file: register indices,
// PCS bit layout and the width of the interrupt source index.
package sys_reg_pkg;

    localparam int unsigned REG_PCS   = 0;
    localparam int unsigned REG_IHA   = 1;
    localparam int unsigned REG_IRA   = 2;
    localparam int unsigned REG_IDN   = 3;
    localparam int unsigned REG_IEN   = 4;
    localparam int unsigned REG_IPEND = 5;

    localparam int unsigned IE_BIT  = 0;
    localparam int unsigned PIE_BIT = 1;

    // Wide enough for up to 16 interrupt sources.
    localparam int unsigned IRQ_IDX_BITS = 4;

    typedef struct packed {
        logic pie;
        logic ie;
    } pcs_t;

    typedef enum logic [2:0] {
        SEL_PCS,
        SEL_IHA,
        SEL_IRA,
        SEL_IDN,
        SEL_IEN,
        SEL_IPEND,
        SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_index(input int unsigned idx);
        case (idx)
            REG_PCS:   return SEL_PCS;
            REG_IHA:   return SEL_IHA;
            REG_IRA:   return SEL_IRA;
            REG_IDN:   return SEL_IDN;
            REG_IEN:   return SEL_IEN;
            REG_IPEND: return SEL_IPEND;
            default:   return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/irq_pending_unit.sv
// Edge detection, pending latches with W1C/ack clear, and a fixed
// lowest-index-wins priority encoder over the enabled pending sources.
module irq_pending_unit
    import sys_reg_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IRQ-1:0]      irq,
    input  logic [NUM_IRQ-1:0]      ien,
    input  logic                    w1c_en,
    input  logic [NUM_IRQ-1:0]      w1c_mask,
    input  logic                    ack,
    output logic [NUM_IRQ-1:0]      pend,
    output logic                    any_req,
    output logic [IRQ_IDX_BITS-1:0] winner_idx
);

    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] clr;
    logic               found;

    assign rise    = irq & ~irq_prev;
    assign req     = pend & ien;
    assign any_req = |req;

    always_comb begin
        winner_idx = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req[i] && !found) begin
                winner_idx = IRQ_IDX_BITS'(i);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (w1c_en && w1c_mask[i]) begin
                clr[i] = 1'b1;
            end
            if (ack && winner_idx == IRQ_IDX_BITS'(i)) begin
                clr[i] = 1'b1;
            end
        end
    end

    // A fresh edge is OR-ed in after the clear so it survives a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= '0;
            pend     <= '0;
        end else begin
            irq_prev <= irq;
            pend     <= (pend & ~clr) | rise;
        end
    end

endmodule

// File: rtl/sys_intr_regfile.sv
// System register file with a multi-source, single-nesting interrupt front end.
// Holds PCS/IHA/IRA/IDN/IEN and arbitrates ack, RETI and WSR updates.
module sys_intr_regfile
    import sys_reg_pkg::*;
#(
    parameter int unsigned DBITS    = 32,
    parameter int unsigned NUM_IRQ  = 4,
    parameter int unsigned IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sys_wrt_en,
    input  logic [IDX_BITS-1:0] wrt_index,
    input  logic [IDX_BITS-1:0] rd_index,
    input  logic [DBITS-1:0]    data_in,
    input  logic [DBITS-1:0]    pc_in,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                is_reti,
    input  logic                int_ack,
    output logic                int_req,
    output logic [DBITS-1:0]    data_out,
    output logic [DBITS-1:0]    handler_addr,
    output logic [DBITS-1:0]    ret_addr,
    output logic [DBITS-1:0]    debug_sys_out
);

    pcs_t                    pcs;
    logic [DBITS-1:0]        iha;
    logic [DBITS-1:0]        ira;
    logic [DBITS-1:0]        idn;
    logic [NUM_IRQ-1:0]      ien;
    logic [NUM_IRQ-1:0]      pend;
    logic                    any_req;
    logic [IRQ_IDX_BITS-1:0] winner_idx;
    logic                    ack_fire;
    reg_sel_e                wr_sel;
    reg_sel_e                rd_sel;
    logic                    wr_pcs;
    logic                    wr_iha;
    logic                    wr_ira;
    logic                    wr_idn;
    logic                    wr_ien;
    logic                    wr_ipend;
    logic [NUM_IRQ-1:0]      pend_after_w1c;
    logic [DBITS-1:0]        rd_val;
    logic [DBITS-1:0]        fwd_val;

    assign wr_sel = sys_wrt_en ? decode_index(32'(wrt_index)) : SEL_NONE;
    assign rd_sel = decode_index(32'(rd_index));

    assign wr_pcs   = (wr_sel == SEL_PCS);
    assign wr_iha   = (wr_sel == SEL_IHA);
    assign wr_ira   = (wr_sel == SEL_IRA);
    assign wr_idn   = (wr_sel == SEL_IDN);
    assign wr_ien   = (wr_sel == SEL_IEN);
    assign wr_ipend = (wr_sel == SEL_IPEND);

    assign int_req  = pcs.ie & any_req;
    assign ack_fire = int_ack & int_req;

    irq_pending_unit #(
        .NUM_IRQ (NUM_IRQ)
    ) u_pending (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .ien        (ien),
        .w1c_en     (wr_ipend),
        .w1c_mask   (data_in[NUM_IRQ-1:0]),
        .ack        (ack_fire),
        .pend       (pend),
        .any_req    (any_req),
        .winner_idx (winner_idx)
    );

    // Per-register precedence: ack first, then RETI (PCS only), then WSR.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcs <= '0;
            iha <= '0;
            ira <= '0;
            idn <= '0;
            ien <= '0;
        end else begin
            if (ack_fire) begin
                pcs.pie <= pcs.ie;
                pcs.ie  <= 1'b0;
            end else if (is_reti) begin
                pcs.ie  <= pcs.pie;
                pcs.pie <= 1'b1;
            end else if (wr_pcs) begin
                pcs.ie  <= data_in[IE_BIT];
                pcs.pie <= data_in[PIE_BIT];
            end

            if (ack_fire) begin
                ira <= pc_in;
            end else if (wr_ira) begin
                ira <= data_in;
            end

            if (ack_fire) begin
                idn <= DBITS'(winner_idx);
            end else if (wr_idn) begin
                idn <= data_in;
            end

            if (wr_iha) begin
                iha <= data_in;
            end

            if (wr_ien) begin
                ien <= data_in[NUM_IRQ-1:0];
            end
        end
    end

    assign pend_after_w1c = pend & ~data_in[NUM_IRQ-1:0];

    always_comb begin
        rd_val = '0;
        case (rd_sel)
            SEL_PCS:   rd_val = DBITS'(pcs);
            SEL_IHA:   rd_val = iha;
            SEL_IRA:   rd_val = ira;
            SEL_IDN:   rd_val = idn;
            SEL_IEN:   rd_val = DBITS'(ien);
            SEL_IPEND: rd_val = DBITS'(pend);
            default:   rd_val = '0;
        endcase
    end

    // Forwarded write data is trimmed to what the register would read back.
    always_comb begin
        fwd_val = '0;
        case (rd_sel)
            SEL_PCS:   fwd_val = DBITS'(data_in[1:0]);
            SEL_IHA:   fwd_val = data_in;
            SEL_IRA:   fwd_val = data_in;
            SEL_IDN:   fwd_val = data_in;
            SEL_IEN:   fwd_val = DBITS'(data_in[NUM_IRQ-1:0]);
            SEL_IPEND: fwd_val = DBITS'(pend_after_w1c);
            default:   fwd_val = '0;
        endcase
    end

    always_comb begin
        data_out = rd_val;
        if (sys_wrt_en && wrt_index == rd_index) begin
            data_out = fwd_val;
        end
    end

    assign handler_addr  = iha;
    assign ret_addr      = ira;
    assign debug_sys_out = DBITS'(pcs);

endmodule

// File: tb/tb_sys_intr_regfile.sv
// Scoreboard bench for sys_intr_regfile: directed scenarios followed by random
// traffic, all checked against an array-based behavioural model.
module tb_sys_intr_regfile;

    localparam int N = 4;

    typedef struct packed {
        logic        rst;
        logic        wen;
        logic [3:0]  widx;
        logic [3:0]  ridx;
        logic [31:0] din;
        logic [31:0] pc;
        logic [3:0]  irq;
        logic        reti;
        logic        ack;
    } stim_t;

    typedef struct packed {
        logic        int_req;
        logic [31:0] dout;
        logic [31:0] ha;
        logic [31:0] ra;
        logic [31:0] dbg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sys_wrt_en;
    logic [3:0]  wrt_index;
    logic [3:0]  rd_index;
    logic [31:0] data_in;
    logic [31:0] pc_in;
    logic [3:0]  irq;
    logic        is_reti;
    logic        int_ack;
    logic        int_req;
    logic [31:0] data_out;
    logic [31:0] handler_addr;
    logic [31:0] ret_addr;
    logic [31:0] debug_sys_out;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [3:0] irq_lvl = '0;

    // Behavioural model state
    bit          m_ie, m_pie;
    logic [31:0] m_iha, m_ira, m_idn;
    bit          m_ien[N];
    bit          m_pend[N];
    bit          m_prev[N];

    sys_intr_regfile #(
        .DBITS    (32),
        .NUM_IRQ  (N),
        .IDX_BITS (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sys_wrt_en    (sys_wrt_en),
        .wrt_index     (wrt_index),
        .rd_index      (rd_index),
        .data_in       (data_in),
        .pc_in         (pc_in),
        .irq           (irq),
        .is_reti       (is_reti),
        .int_ack       (int_ack),
        .int_req       (int_req),
        .data_out      (data_out),
        .handler_addr  (handler_addr),
        .ret_addr      (ret_addr),
        .debug_sys_out (debug_sys_out)
    );

    always #5 clk = ~clk;

    function automatic int m_winner();
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && m_ien[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit m_req();
        return m_ie && (m_winner() >= 0);
    endfunction

    function automatic logic [31:0] m_pack(input bit a[N]);
        logic [31:0] v = 0;
        for (int i = 0; i < N; i++) v += a[i] ? (32'd1 << i) : 32'd0;
        return v;
    endfunction

    function automatic logic [31:0] m_read(input stim_t s);
        logic [31:0] v;
        if (s.wen && s.widx == s.ridx) begin
            case (s.ridx)
                0:       v = s.din & 32'h3;
                1, 2, 3: v = s.din;
                4:       v = s.din & 32'hF;
                5:       v = m_pack(m_pend) & ~s.din;
                default: v = 0;
            endcase
        end else begin
            case (s.ridx)
                0:       v = (m_pie ? 32'd2 : 32'd0) + (m_ie ? 32'd1 : 32'd0);
                1:       v = m_iha;
                2:       v = m_ira;
                3:       v = m_idn;
                4:       v = m_pack(m_ien);
                5:       v = m_pack(m_pend);
                default: v = 0;
            endcase
        end
        return v;
    endfunction

    task automatic m_clear();
        m_ie = 0; m_pie = 0; m_iha = 0; m_ira = 0; m_idn = 0;
        for (int i = 0; i < N; i++) begin
            m_ien[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
        end
    endtask

    task automatic m_step(input stim_t s);
        int w;
        bit acked;
        bit p;
        if (s.rst) begin
            m_clear();
            return;
        end
        w = m_winner();
        acked = s.ack && m_req();
        for (int i = 0; i < N; i++) begin
            p = m_pend[i];
            if (s.wen && s.widx == 5 && s.din[i]) p = 0;
            if (acked && i == w) p = 0;
            if (s.irq[i] && !m_prev[i]) p = 1;
            m_pend[i] = p;
        end
        if (acked) begin
            m_pie = m_ie; m_ie = 0;
        end else if (s.reti) begin
            m_ie = m_pie; m_pie = 1;
        end else if (s.wen && s.widx == 0) begin
            m_ie = s.din[0]; m_pie = s.din[1];
        end
        if (acked) m_ira = s.pc;
        else if (s.wen && s.widx == 2) m_ira = s.din;
        if (acked) m_idn = 32'(w);
        else if (s.wen && s.widx == 3) m_idn = s.din;
        if (s.wen && s.widx == 1) m_iha = s.din;
        if (s.wen && s.widx == 4) begin
            for (int i = 0; i < N; i++) m_ien[i] = s.din[i];
        end
        for (int i = 0; i < N; i++) m_prev[i] = s.irq[i];
    endtask

    function automatic stim_t base();
        stim_t s = '0;
        s.irq = irq_lvl;
        return s;
    endfunction

    // Apply one cycle of stimulus, queue the expected outputs, advance the model.
    task automatic drive(input stim_t s);
        exp_t e;
        reset = s.rst; sys_wrt_en = s.wen; wrt_index = s.widx; rd_index = s.ridx;
        data_in = s.din; pc_in = s.pc; irq = s.irq; is_reti = s.reti; int_ack = s.ack;
        e.int_req = m_req();
        e.dout    = m_read(s);
        e.ha      = m_iha;
        e.ra      = m_ira;
        e.dbg     = (m_pie ? 32'd2 : 32'd0) + (m_ie ? 32'd1 : 32'd0);
        sb.push_back(e);
        m_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic t_idle(input int n);
        for (int i = 0; i < n; i++) drive(base());
    endtask

    task automatic t_wsr(input logic [3:0] idx, input logic [31:0] d);
        stim_t s = base();
        s.wen = 1; s.widx = idx; s.din = d; s.ridx = idx;
        drive(s);
    endtask

    task automatic t_rsr(input logic [3:0] idx);
        stim_t s = base();
        s.ridx = idx;
        drive(s);
    endtask

    task automatic t_ack(input logic [31:0] pc, input logic [3:0] ridx);
        stim_t s = base();
        s.ack = 1; s.pc = pc; s.ridx = ridx;
        drive(s);
    endtask

    task automatic t_reti();
        stim_t s = base();
        s.reti = 1;
        drive(s);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("int_req", 32'(int_req), 32'(e.int_req));
            chk("data_out", data_out, e.dout);
            chk("handler_addr", handler_addr, e.ha);
            chk("ret_addr", ret_addr, e.ra);
            chk("debug_sys_out", debug_sys_out, e.dbg);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        reset = 1; sys_wrt_en = 0; wrt_index = 0; rd_index = 0; data_in = 0;
        pc_in = 0; irq = 0; is_reti = 0; int_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        m_clear();

        // Reset state, then single interrupt taken on irq[2]
        t_rsr(0);
        t_wsr(4, 32'hF);
        t_wsr(0, 32'h1);
        t_idle(5);
        irq_lvl = 4'b0100; t_rsr(5);
        irq_lvl = 4'b0000; t_rsr(5);
        t_ack(32'h100, 3);
        t_rsr(3); t_rsr(2); t_rsr(0);

        // Two simultaneous edges: lowest index first, the other after RETI
        t_wsr(0, 32'h1);
        irq_lvl = 4'b1010; t_idle(1);
        t_ack(32'h200, 3);
        t_rsr(3);
        t_reti();
        t_ack(32'h204, 3);
        t_rsr(3);
        irq_lvl = 4'b0000; t_reti();

        // Masked source stays pending; enabling later raises int_req; W1C clears
        t_wsr(0, 32'h1);
        t_wsr(4, 32'h1);
        irq_lvl = 4'b0100; t_idle(1);
        irq_lvl = 4'b0000; t_rsr(5); t_rsr(5);
        t_wsr(4, 32'h4);
        t_idle(2);
        t_ack(32'h300, 3);
        t_wsr(0, 32'h1);
        t_wsr(4, 32'h1);
        irq_lvl = 4'b0100; t_idle(1);
        irq_lvl = 4'b0000; t_wsr(5, 32'h4);
        t_wsr(4, 32'h4);
        t_idle(2);

        // WSR IDN collides with ack; RSR PCS forwards a concurrent WSR
        t_wsr(4, 32'hF);
        t_wsr(0, 32'h1);
        irq_lvl = 4'b0001; t_idle(1);
        irq_lvl = 4'b0000; t_idle(1);
        s = base(); s.ack = 1; s.pc = 32'h400; s.wen = 1; s.widx = 3; s.din = 32'h55; s.ridx = 3;
        drive(s);
        t_rsr(3);
        t_wsr(0, 32'h3);
        t_rsr(0);

        // New edge on irq[0] in the same cycle its pending bit is acked
        irq_lvl = 4'b0001; t_idle(1);
        irq_lvl = 4'b0000; t_idle(1);
        irq_lvl = 4'b0001; t_ack(32'h500, 5);
        irq_lvl = 4'b0000; t_rsr(5);
        t_reti();
        t_idle(2);

        // Reset wins over a concurrent ack and irq edge
        t_wsr(0, 32'h1);
        t_rsr(2);
        s = base(); s.rst = 1; s.ack = 1; s.pc = 32'hDEAD; s.irq = 4'b1000; s.ridx = 2;
        drive(s);
        irq_lvl = 4'b1000; t_rsr(2);
        t_rsr(5);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            s = '0;
            s.rst  = ($urandom_range(0, 99) == 0);
            s.wen  = ($urandom_range(0, 3) == 0);
            s.widx = 4'($urandom_range(0, 7));
            s.ridx = ($urandom_range(0, 3) == 0) ? s.widx : 4'($urandom_range(0, 7));
            s.din  = $urandom();
            if (s.wen && s.widx == 0 && $urandom_range(0, 1) == 1) s.din[0] = 1'b1;
            s.pc   = $urandom();
            if ($urandom_range(0, 2) == 0) irq_lvl = 4'($urandom());
            s.irq  = irq_lvl;
            s.reti = ($urandom_range(0, 7) == 0);
            s.ack  = ($urandom_range(0, 2) == 0);
            drive(s);
        end

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
